pipe_stage_skid: RTL and testbench

//  Generic inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  in_ready_o is driven from a flop, so no combinational ready path crosses the stage.

---
 rtl/pipe_stage_skid.sv | 197 +++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Inter-stage pipeline register with a valid/ready handshake and a two-entry
// skid buffer (main = head, skid = overflow). The upstream ready is a
// registered signal, so no combinational ready path runs across the stage.
// While the stage holds no valid beat, out_data_o shows NOP_VAL (a bubble).
// flush_i empties the stage on a branch redirect.
//
// Handshake: a beat moves across an interface on a rising clk_i edge when
// valid and ready are both high in the cycle before it. A producer holds
// valid and data until that happens. in_valid_i must not depend on
// in_ready_o.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, the stage adds two saturating performance counters,
//   stall_cnt_o and bubble_cnt_o. They clear only on rst_i.
//
// Ports
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous, active-high reset
//   in_valid_i   in   1       upstream data valid
//   in_data_i    in   DATA_W  upstream payload
//   in_ready_o   out  1       stage can accept a beat this cycle (flop)
//   out_valid_o  out  1       stage holds a valid beat (flop)
//   out_data_o   out  DATA_W  head payload, or NOP_VAL while out_valid_o=0
//   out_ready_i  in   1       downstream accepts the head beat
//   flush_i      in   1       discard all held and incoming beats this cycle
//   stall_cnt_o  out  CNT_W   [PERF] cycles with out_valid_o & ~out_ready_i
//   bubble_cnt_o out  CNT_W   [PERF] cycles with ~out_valid_o after reset
//   state_dbg_o  out  2       current FSM state {skid_v, main_v}
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned          DATA_W  = 32,
  parameter logic [DATA_W-1:0]    NOP_VAL = 'h13,
  parameter int unsigned          CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
  output logic [1:0]        state_dbg_o
);

  // The state encoding is {skid_v, main_v}. This makes out_valid_o and
  // in_ready_o come straight from the state flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic in_fire;
  logic out_fire;

  // Load controls produced by the next-state logic.
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  // -------------------------------------------------------------------------
  // Status and handshake
  // -------------------------------------------------------------------------
  assign out_valid_o = state[0];
  assign in_ready_o  = ~state[1];
  assign state_dbg_o = state;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // The payload flops are not reset. Masking the output keeps stale or
  // uninitialised contents from reaching the next stage.
  assign out_data_o = out_valid_o ? main_q : NOP_VAL;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and load-control logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;

    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_next   = ST_ONE;
        end
      end

      ST_ONE: begin
        if (in_fire && out_fire) begin
          // The head leaves as the new beat arrives. The new beat replaces
          // the head directly, which sustains one beat per cycle.
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid_in = 1'b1;
          state_next   = ST_FULL;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // in_ready_o is low here, so only the drain path exists. Moving skid
        // into main keeps FIFO order.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_next     = ST_ONE;
        end
      end

      default: begin
        state_next = ST_EMPTY;
      end
    endcase

    // A flush wins over every transition. Any payload load in this cycle is
    // harmless because both valid bits clear.
    if (flush_i) begin
      state_next = ST_EMPTY;
    end
  end

  // -------------------------------------------------------------------------
  // Payload storage (not reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (load_main_in) begin
      main_q <= in_data_i;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_skid_in) begin
      skid_q <= in_data_i;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters. Each one saturates at all-ones. A flush does not
  // clear them, and an empty cycle caused by a flush counts as a bubble.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else if (!out_valid_o && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed bench for pipe_stage_skid. The driver pushes each accepted beat
// into exp_q. A negedge monitor pops from exp_q and compares whenever the
// stage presents an output handshake. The monitor also checks the bubble
// value and that held data stays stable.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int W = 32;
  localparam logic [W-1:0] NOP = 32'h13;

  // clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;
  logic [1:0]   state_dbg;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  bubble_cnt;
  logic [1:0]   sat_stall_cnt;
  logic [1:0]   sat_bubble_cnt;
  logic         sat_in_ready;
  logic         sat_out_valid;
  logic [W-1:0] sat_out_data;
  logic [1:0]   sat_state_dbg;
`endif

  pipe_stage_skid #(.DATA_W(W), .NOP_VAL(32'h13), .CNT_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .flush_i     (flush),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt_o (stall_cnt),
    .bubble_cnt_o(bubble_cnt),
`endif
    .state_dbg_o (state_dbg)
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_skid #(.DATA_W(W), .NOP_VAL(32'h13), .CNT_W(2)) dut_sat (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (sat_in_ready),
    .out_valid_o (sat_out_valid),
    .out_data_o  (sat_out_data),
    .out_ready_i (out_ready),
    .flush_i     (flush),
    .stall_cnt_o (sat_stall_cnt),
    .bubble_cnt_o(sat_bubble_cnt),
    .state_dbg_o (sat_state_dbg)
  );
`endif

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (prev_stall) check("hold", out_data, prev_data);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%08h expected none at %0t", out_data, $time);
          end else begin
            check("out_beat", out_data, exp_q.pop_front());
          end
        end
      end else begin
        check("bubble_val", out_data, NOP);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    logic         fire;
    logic [W-1:0] d;
    fire = in_valid && in_ready && !flush;
    d    = in_data;
    @(posedge clk);
    #1;
    if (fire) exp_q.push_back(d);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // --- reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, NOP);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // --- scenario 1: single beat, one-cycle latency
    drive(1'b1, 32'h0000_0093, 1'b1);
    check("s1_pre_data", out_data, NOP);
    step();
    drive(1'b0, '0, 1'b1);
    check("s1_out_valid", {31'd0, out_valid}, 32'd1);
    check("s1_out_data", out_data, 32'h0000_0093);
    idle(2);

    // --- scenario 2: back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b1);
      check("s2_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 1) check("s2_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    drive(1'b0, '0, 1'b1);
    idle(2);
    check("s2_drained", exp_q.size(), 32'd0);

    // --- scenario 3: fill to FULL, then drain in order
    drive(1'b1, 32'hA5A5_000A, 1'b0);
    step();
    drive(1'b1, 32'hA5A5_000B, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    check("s3_in_ready", {31'd0, in_ready}, 32'd0);
    check("s3_state_full", {30'd0, state_dbg}, 32'd3);
    check("s3_head", out_data, 32'hA5A5_000A);
    // offered beat must not be taken while FULL
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    idle(2);
    drive(1'b0, '0, 1'b0);
    check("s3_head_held", out_data, 32'hA5A5_000A);
    drive(1'b0, '0, 1'b1);
    step();
    check("s3_ready_after_a", {31'd0, in_ready}, 32'd1);
    check("s3_second", out_data, 32'hA5A5_000B);
    step();
    check("s3_empty", {31'd0, out_valid}, 32'd0);

    // --- scenario 4: flush while FULL with an incoming beat
    drive(1'b1, 32'h0000_00D1, 1'b0);
    step();
    drive(1'b1, 32'h0000_00D2, 1'b0);
    step();
    drive(1'b1, 32'h0000_00C0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    drive(1'b0, '0, 1'b1);
    check("s4_out_valid", {31'd0, out_valid}, 32'd0);
    check("s4_out_data", out_data, NOP);
    check("s4_in_ready", {31'd0, in_ready}, 32'd1);
    idle(3);

    // flush in ONE with out_fire in the same cycle: the head still leaves
    drive(1'b1, 32'h0000_00F1, 1'b0);
    step();
    drive(1'b1, 32'h0000_00F2, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("s4b_popped", exp_q.size(), 32'd0);
    exp_q.delete();
    drive(1'b0, '0, 1'b1);
    check("s4b_out_valid", {31'd0, out_valid}, 32'd0);
    idle(2);

    // --- scenario 5: asynchronous reset while ONE
    drive(1'b1, 32'h0000_0055, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    check("s5_one", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("s5_async_valid", {31'd0, out_valid}, 32'd0);
    check("s5_async_data", out_data, NOP);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("s5_post_ready", {31'd0, in_ready}, 32'd1);
    check("s5_post_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h0000_0037, 1'b1);
    step();
    drive(1'b0, '0, 1'b1);
    check("s5_beat", out_data, 32'h0000_0037);
    idle(2);

`ifdef PIPE_STAGE_PERF_EN
    // --- scenario 6: counters after a fresh reset
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    drive(1'b1, 32'h0000_0066, 1'b0);
    step();                          // bubble 1
    drive(1'b0, '0, 1'b0);
    idle(3);                         // stall 3
    drive(1'b0, '0, 1'b1);
    step();                          // drained: neither
    idle(2);                         // bubble 3
    check("s6_stall", stall_cnt, 32'd3);
    check("s6_bubble", bubble_cnt, 32'd3);
    check("s6_sat_stall", {30'd0, sat_stall_cnt}, 32'd3);
    check("s6_sat_bubble", {30'd0, sat_bubble_cnt}, 32'd3);
    drive(1'b1, 32'h0000_0067, 1'b0);
    step();                          // bubble 4 / saturated 3
    drive(1'b0, '0, 1'b0);
    idle(2);                         // stall 5 / saturated 3
    check("s6_stall2", stall_cnt, 32'd5);
    check("s6_bubble2", bubble_cnt, 32'd4);
    check("s6_sat_stall2", {30'd0, sat_stall_cnt}, 32'd3);
    check("s6_sat_bubble2", {30'd0, sat_bubble_cnt}, 32'd3);
    drive(1'b0, '0, 1'b1);
    idle(2);
`endif

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
